// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if
//   Bundles the request/stream handshake and the four flash pins of the
//   SPI flash reader.
//   slave  : the reader itself (drives busy/done/rd_*/flash_csb/clk/io0)
//   master : its environment, i.e. the user logic plus the flash device
//            (drives start/addr/len/rd_ready/flash_io1)
interface spi_flash_reader_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [23:0]      addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             flash_csb;
  logic             flash_clk;
  logic             flash_io0;
  logic             flash_io1;

  modport slave (
    input  start, addr, len, rd_ready, flash_io1,
    output busy, done, rd_data, rd_valid, flash_csb, flash_clk, flash_io0
  );

  modport master (
    output start, addr, len, rd_ready, flash_io1,
    input  busy, done, rd_data, rd_valid, flash_csb, flash_clk, flash_io0
  );
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//   SPI mode-0 initiator issuing READ (0x03) to a serial flash and returning
//   the received bytes one at a time over a valid/ready stream. SCK is held
//   low between bytes while the consumer back-pressures.
// Parameters
//   CLK_DIV : SCK half-period in clock cycles (>=1)
//   LEN_W   : width of the byte-count request field
// Ports
//   clock   : system clock, posedge
//   resetb  : asynchronous active-low reset
//   bus     : request (start/addr/len), status (busy/done), read stream
//             (rd_data/rd_valid/rd_ready) and flash pins (csb/clk/io0/io1)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; csb high, SCK low
// CSS   | csb low, SCK low for CLK_DIV cycles; first MOSI bit presented
// CMD   | shifting the 8 command bits
// ADR   | shifting the 24 address bits
// DAT   | clocking in one data byte on MISO, MOSI held 0
// HLD   | byte waiting on the consumer; SCK low, csb low
// CSH   | csb hold after the final falling edge, then wait for last accept
// DONE  | one-cycle done pulse, busy cleared on exit
module spi_flash_reader #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 8
) (
  input  logic               clock,
  input  logic               resetb,
  spi_flash_reader_if.slave  bus
);

  localparam logic [7:0] READ_CMD = 8'h03;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSS,
    S_CMD,
    S_ADR,
    S_DAT,
    S_HLD,
    S_CSH,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [4:0]       bit_q;
  logic [30:0]      tx_q;
  logic [7:0]       rx_q;
  logic [LEN_W-1:0] len_q;
  logic             csb_q;
  logic             sck_q;
  logic             io0_q;
  logic             busy_q;
  logic             done_q;
  logic             valid_q;
  logic [7:0]       data_q;

  logic accept_d;
  logic div_tc_d;

  assign accept_d = valid_q & bus.rd_ready;
  assign div_tc_d = (div_q == '0);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      len_q   <= '0;
      csb_q   <= 1'b1;
      sck_q   <= 1'b0;
      io0_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // Stream handshake is independent of the state: the last byte may be
      // accepted while the FSM is already in CSH.
      if (accept_d) begin
        valid_q <= 1'b0;
        len_q   <= len_q - 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.len == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              len_q   <= bus.len;
              // First MOSI bit goes out now; tx_q holds the remaining 31.
              io0_q   <= READ_CMD[7];
              tx_q    <= {READ_CMD[6:0], bus.addr};
              csb_q   <= 1'b0;
              div_q   <= DIV_LOAD;
              state_q <= S_CSS;
            end
          end
        end

        S_CSS: begin
          if (div_tc_d) begin
            sck_q   <= 1'b1;
            div_q   <= DIV_LOAD;
            bit_q   <= 5'd7;
            state_q <= S_CMD;
          end else begin
            div_q <= div_q - 1'b1;
          end
        end

        S_CMD, S_ADR, S_DAT: begin
          if (!div_tc_d) begin
            div_q <= div_q - 1'b1;
          end else begin
            div_q <= DIV_LOAD;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              // Rising edge: MISO sample point.
              if (state_q == S_DAT) begin
                rx_q <= {rx_q[6:0], bus.flash_io1};
              end
            end else begin
              // Falling edge: advance MOSI, count the bit just completed.
              bit_q <= bit_q - 1'b1;
              if (state_q != S_DAT) begin
                io0_q <= tx_q[30];
                tx_q  <= {tx_q[29:0], 1'b0};
              end
              if (bit_q == 5'd0) begin
                case (state_q)
                  S_CMD: begin
                    bit_q   <= 5'd23;
                    state_q <= S_ADR;
                  end
                  S_ADR: begin
                    bit_q   <= 5'd7;
                    state_q <= S_DAT;
                  end
                  default: begin
                    // All earlier bytes were accepted before leaving HLD,
                    // so len_q still counts the byte being delivered.
                    bit_q   <= 5'd7;
                    data_q  <= rx_q;
                    valid_q <= 1'b1;
                    if (len_q == LEN_W'(1)) begin
                      state_q <= S_CSH;
                    end else begin
                      state_q <= S_HLD;
                    end
                  end
                endcase
              end
            end
          end
        end

        S_HLD: begin
          if (accept_d) begin
            div_q   <= DIV_LOAD;
            state_q <= S_DAT;
          end
        end

        S_CSH: begin
          if (!div_tc_d) begin
            div_q <= div_q - 1'b1;
          end else if (!valid_q || bus.rd_ready) begin
            csb_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_data   = data_q;
  assign bus.rd_valid  = valid_q;
  assign bus.flash_csb = csb_q;
  assign bus.flash_clk = sck_q;
  assign bus.flash_io0 = io0_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
`timescale 1ns/1ps
module tb_spi_flash_reader;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        start_r = 1'b0;
  logic [23:0] addr_r = '0;
  logic [7:0]  len_r = '0;
  logic        rd_ready_r = 1'b0;
  logic        mon_clr = 1'b0;
  int          sel = 0;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  // Three readers with different dividers; only the selected one is driven
  // and observed, so one flash model and one monitor serve all of them.
  spi_flash_reader_if #(.LEN_W(8)) bus0 ();
  spi_flash_reader_if #(.LEN_W(8)) bus1 ();
  spi_flash_reader_if #(.LEN_W(8)) bus2 ();

  spi_flash_reader #(.CLK_DIV(2), .LEN_W(8)) dut0 (.clock(clock), .resetb(resetb), .bus(bus0.slave));
  spi_flash_reader #(.CLK_DIV(1), .LEN_W(8)) dut1 (.clock(clock), .resetb(resetb), .bus(bus1.slave));
  spi_flash_reader #(.CLK_DIV(4), .LEN_W(8)) dut2 (.clock(clock), .resetb(resetb), .bus(bus2.slave));

  logic miso;

  assign bus0.start = start_r & (sel == 0);
  assign bus1.start = start_r & (sel == 1);
  assign bus2.start = start_r & (sel == 2);
  assign bus0.addr = addr_r;
  assign bus1.addr = addr_r;
  assign bus2.addr = addr_r;
  assign bus0.len = len_r;
  assign bus1.len = len_r;
  assign bus2.len = len_r;
  assign bus0.rd_ready = rd_ready_r;
  assign bus1.rd_ready = rd_ready_r;
  assign bus2.rd_ready = rd_ready_r;
  assign bus0.flash_io1 = miso;
  assign bus1.flash_io1 = miso;
  assign bus2.flash_io1 = miso;

  logic       busy_m, done_m, valid_m, csb_m, sck_m, io0_m;
  logic [7:0] data_m;

  always_comb begin
    busy_m = bus0.busy; done_m = bus0.done; valid_m = bus0.rd_valid;
    csb_m = bus0.flash_csb; sck_m = bus0.flash_clk; io0_m = bus0.flash_io0;
    data_m = bus0.rd_data;
    case (sel)
      1: begin
        busy_m = bus1.busy; done_m = bus1.done; valid_m = bus1.rd_valid;
        csb_m = bus1.flash_csb; sck_m = bus1.flash_clk; io0_m = bus1.flash_io0;
        data_m = bus1.rd_data;
      end
      2: begin
        busy_m = bus2.busy; done_m = bus2.done; valid_m = bus2.rd_valid;
        csb_m = bus2.flash_csb; sck_m = bus2.flash_clk; io0_m = bus2.flash_io0;
        data_m = bus2.rd_data;
      end
      default: ;
    endcase
  end

  // Flash model: 32 MOSI bits (command + address) captured on rising SCK,
  // data shifted out MSB first on falling SCK from the captured address.
  logic [7:0]  mem [0:511];
  logic [31:0] fm_sh = '0;
  int          fm_cnt = 0;

  always @(posedge sck_m or posedge csb_m) begin
    if (csb_m) begin
      fm_cnt <= 0;
    end else begin
      if (fm_cnt < 32) fm_sh <= {fm_sh[30:0], io0_m};
      fm_cnt <= fm_cnt + 1;
    end
  end

  int fm_k;
  logic [8:0] fm_idx;
  always @(negedge sck_m or posedge csb_m) begin
    if (csb_m) begin
      miso <= 1'b0;
    end else if (fm_cnt >= 32) begin
      fm_k   = fm_cnt - 32;
      fm_idx = fm_sh[8:0] + 9'(fm_k / 8);
      miso  <= mem[fm_idx][7 - (fm_k % 8)];
    end
  end

  // Monitor: handshakes, done pulses, SCK rises and csb edges.
  logic [7:0] got [0:7];
  int hs_n = 0, done_n = 0, rise_n = 0, csb_rise_n = 0, csb_fall_n = 0;
  int cyc = 0, r1 = 0, r2 = 0;
  logic prev_sck = 1'b0, prev_csb = 1'b1;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    prev_sck <= sck_m;
    prev_csb <= csb_m;
    if (mon_clr) begin
      hs_n <= 0; done_n <= 0; rise_n <= 0; csb_rise_n <= 0; csb_fall_n <= 0;
      r1 <= 0; r2 <= 0;
    end else begin
      if (valid_m && rd_ready_r) begin
        if (hs_n < 8) got[hs_n] <= data_m;
        hs_n <= hs_n + 1;
      end
      if (done_m) done_n <= done_n + 1;
      if (sck_m && !prev_sck) begin
        rise_n <= rise_n + 1;
        if (rise_n == 0) r1 <= cyc;
        if (rise_n == 1) r2 <= cyc;
      end
      if (csb_m && !prev_csb) csb_rise_n <= csb_rise_n + 1;
      if (!csb_m && prev_csb) csb_fall_n <= csb_fall_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clock); mon_clr = 1'b1;
    @(negedge clock); mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [23:0] a, input logic [7:0] l);
    @(negedge clock);
    start_r = 1'b1; addr_r = a; len_r = l;
    @(negedge clock);
    start_r = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done_m) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_four(input string tag);
    check({tag, "_hs"}, 32'(hs_n), 32'd4);
    check({tag, "_b0"}, 32'(got[0]), 32'hDE);
    check({tag, "_b1"}, 32'(got[1]), 32'hAD);
    check({tag, "_b2"}, 32'(got[2]), 32'hBE);
    check({tag, "_b3"}, 32'(got[3]), 32'hEF);
    check({tag, "_cmd"}, 32'(fm_sh[31:24]), 32'h03);
    check({tag, "_addr"}, 32'(fm_sh[23:0]), 32'h000000);
    check({tag, "_csb_fall"}, 32'(csb_fall_n), 32'd1);
    check({tag, "_csb_rise"}, 32'(csb_rise_n), 32'd1);
    check({tag, "_done_n"}, 32'(done_n), 32'd1);
    check({tag, "_busy_end"}, 32'(busy_m), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 1);
    mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'hBE; mem[3] = 8'hEF;
    mem[9'h102] = 8'h5A; mem[9'h103] = 8'hC3; mem[9'h104] = 8'h77;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_csb", 32'(csb_m), 32'd1);
    check("rst_sck", 32'(sck_m), 32'd0);
    check("rst_io0", 32'(io0_m), 32'd0);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_done", 32'(done_m), 32'd0);
    check("rst_valid", 32'(valid_m), 32'd0);
    check("rst_data", 32'(data_m), 32'd0);
    @(negedge clock); resetb = 1'b1;

    // 1: four bytes from 0, consumer always ready
    rd_ready_r = 1'b1;
    clear_mon();
    pulse_start(24'h0, 8'd4);
    check("t1_busy_start", 32'(busy_m), 32'd1);
    check("t1_csb_start", 32'(csb_m), 32'd0);
    wait_done(1000, "t1");
    check_four("t1");

    // 2: back-pressure for 20 cycles after the first byte
    clear_mon();
    pulse_start(24'h0, 8'd4);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (hs_n == 1) begin seen = 1'b1; break; end
    end
    check("t2_first_hs", 32'(seen), 32'd1);
    rd_ready_r = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (valid_m) begin seen = 1'b1; break; end
    end
    check("t2_second_valid", 32'(seen), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("t2_hold_sck", 32'(sck_m), 32'd0);
      check("t2_hold_csb", 32'(csb_m), 32'd0);
      check("t2_hold_valid", 32'(valid_m), 32'd1);
      check("t2_hold_data", 32'(data_m), 32'hAD);
    end
    rd_ready_r = 1'b1;
    wait_done(1000, "t2");
    check_four("t2");

    // 3: zero-length request
    clear_mon();
    pulse_start(24'h000123, 8'd0);
    check("t3_done", 32'(done_m), 32'd1);
    check("t3_busy", 32'(busy_m), 32'd1);
    check("t3_csb", 32'(csb_m), 32'd1);
    @(negedge clock);
    check("t3_done_after", 32'(done_m), 32'd0);
    check("t3_busy_after", 32'(busy_m), 32'd0);
    repeat (5) @(negedge clock);
    check("t3_sck_rises", 32'(rise_n), 32'd0);
    check("t3_csb_fall", 32'(csb_fall_n), 32'd0);
    check("t3_done_n", 32'(done_n), 32'd1);

    // 4: two bytes from 0x102, extra start mid-transfer
    clear_mon();
    pulse_start(24'h000102, 8'd2);
    repeat (30) @(negedge clock);
    pulse_start(24'h000000, 8'd4);
    addr_r = 24'hFFFFFF; len_r = 8'd9;
    wait_done(1000, "t4");
    repeat (10) @(negedge clock);
    check("t4_hs", 32'(hs_n), 32'd2);
    check("t4_b0", 32'(got[0]), 32'h5A);
    check("t4_b1", 32'(got[1]), 32'hC3);
    check("t4_addr", 32'(fm_sh[23:0]), 32'h000102);
    check("t4_done_n", 32'(done_n), 32'd1);
    check("t4_csb_fall", 32'(csb_fall_n), 32'd1);
    check("t4_busy_end", 32'(busy_m), 32'd0);

    // 5: asynchronous reset during the address phase
    clear_mon();
    pulse_start(24'h0, 8'd4);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (rise_n >= 14) begin seen = 1'b1; break; end
    end
    check("t5_reach_adr", 32'(seen), 32'd1);
    #1 resetb = 1'b0;
    #1;
    check("t5_rst_csb", 32'(csb_m), 32'd1);
    check("t5_rst_sck", 32'(sck_m), 32'd0);
    check("t5_rst_busy", 32'(busy_m), 32'd0);
    check("t5_rst_done", 32'(done_m), 32'd0);
    @(negedge clock); resetb = 1'b1;
    check("t5_no_done", 32'(done_n), 32'd0);
    clear_mon();
    pulse_start(24'h0, 8'd1);
    wait_done(1000, "t5");
    check("t5_hs", 32'(hs_n), 32'd1);
    check("t5_b0", 32'(got[0]), 32'hDE);

    // 6: divider 1 and divider 4 builds
    sel = 1;
    clear_mon();
    pulse_start(24'h0, 8'd4);
    wait_done(2000, "t6a");
    check_four("t6a");
    check("t6a_period", 32'(r2 - r1), 32'd2);

    sel = 2;
    clear_mon();
    pulse_start(24'h0, 8'd4);
    wait_done(2000, "t6b");
    check_four("t6b");
    check("t6b_period", 32'(r2 - r1), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
